// File: rtl/data_memory_unit.sv
// data_memory_unit: parametrised single-port data RAM with post-reset clear, read pipeline and range check
module data_memory_unit #(
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memory_enable,
  input  logic                  is_st,
  input  logic                  is_ld,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_error
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t                  state_q;
  logic [IW-1:0]           cnt_q;
  logic                    ready_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic                    in_range, acc, st_acc, ld_acc;
  logic [DATA_WIDTH-1:0]   rd_d;
  assign in_range = 32'(address) < DEPTH;
  assign acc      = !rst && memory_enable && ready_q && (is_st || is_ld);
  assign st_acc   = acc && is_st;
  assign ld_acc   = acc && is_ld && !is_st;
  assign rd_d     = in_range ? mem[address[IW-1:0]] : '0;
  // Control FSM: walk the clear counter over every word, then sit in IDLE accepting requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + IW'(1);
      if (cnt_q == IW'(DEPTH - 1)) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
      end
    end else begin
      ready_q <= 1'b1;
    end
  end
  // Storage: clear writes zeros; otherwise in-range accepted stores land here
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) mem[cnt_q] <= '0;
    else if (st_acc && in_range) mem[address[IW-1:0]] <= data_in;
  end
  // Read pipeline: valid and data advance together; each stage holds its data when no load passes through
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q[0] <= ld_acc;
      dat_q[0] <= ld_acc ? rd_d : dat_q[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
      err_q <= acc && !in_range;
    end
  end
  assign ready      = ready_q;
  assign data_out   = dat_q[READ_LATENCY-1];
  assign data_valid = vld_q[READ_LATENCY-1];
  assign addr_error = err_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed bench with a queue-based reference model checked every cycle
module tb_data_memory_unit;
  localparam int DEPTH = 1000;
  localparam int RL    = 3;
  logic        clk = 0;
  logic        rst = 1;
  logic        en = 0, st = 0, ld = 0;
  logic [9:0]  addr = '0;
  logic [17:0] din = '0;
  logic        ready, data_valid, addr_error;
  logic [17:0] data_out;
  int          errors = 0, checks = 0;

  data_memory_unit #(.DATA_WIDTH(18), .ADDR_WIDTH(10), .DEPTH(DEPTH), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .memory_enable(en), .is_st(st), .is_ld(ld), .address(addr), .data_in(din),
    .ready(ready), .data_out(data_out), .data_valid(data_valid), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [17:0] d;} pend_t;
  pend_t       q[$];
  logic [17:0] mmem [DEPTH];
  int          edge_n = 0, since = 0;
  bit          started = 0, acc;
  logic        e_ready = 0, e_dv = 0, e_err = 0;
  logic [17:0] e_dout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: words are zeroed one per cycle after reset, loads come out RL-1 edges after acceptance
  always @(posedge clk) begin
    edge_n++;
    started = 1;
    if (rst) begin
      since = 0;
      q.delete();
      e_ready = 0; e_dv = 0; e_err = 0; e_dout = '0;
    end else begin
      acc = e_ready && en && (st || ld);
      since++;
      if (since <= DEPTH) mmem[since-1] = '0;
      e_err = acc && addr >= DEPTH;
      if (acc && st) begin
        if (addr < DEPTH) mmem[addr] = din;
      end else if (acc && ld) begin
        q.push_back('{edge_n + RL - 1, (addr < DEPTH) ? mmem[addr] : 18'h0});
      end
      e_dv = 0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        e_dv = 1;
        e_dout = q[0].d;
        void'(q.pop_front());
      end
      e_ready = since >= DEPTH;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", ready, e_ready);
      chk("data_valid", data_valid, e_dv);
      chk("data_out", data_out, e_dout);
      chk("addr_error", addr_error, e_err);
    end
  end

  task automatic cyc(input logic e, input logic s, input logic l, input logic [9:0] a, input logic [17:0] d);
    en = e; st = s; ld = l; addr = a; din = d;
    @(negedge clk);
  endtask

  task automatic ld_chk(input logic [9:0] a, input logic [17:0] e, input string nm);
    cyc(1, 0, 1, a, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk({nm, " dv"}, data_valid, 1);
    chk({nm, " data"}, data_out, e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles", n, DEPTH);
  endtask

  task automatic pulse_rst();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", ready, 0);
    chk("rst dv", data_valid, 0);
    chk("rst dout", data_out, 0);
    chk("rst err", addr_error, 0);
    rst = 0;
    wait_ready();
  endtask

  initial begin
    pulse_rst();
    cyc(1, 1, 0, 5, 18'h3FFFF);
    ld_chk(5, 18'h3FFFF, "preload5");
    pulse_rst();
    ld_chk(5, 18'h0, "cleared5");
    cyc(1, 1, 0, 10'h00F, 18'h2A5A5);
    ld_chk(10'h00F, 18'h2A5A5, "st_ld_0F");
    cyc(0, 0, 0, 0, 0);
    chk("hold dv", data_valid, 0);
    chk("hold data", data_out, 18'h2A5A5);
    cyc(1, 1, 0, 1, 18'h11);
    cyc(1, 1, 0, 2, 18'h22);
    cyc(1, 1, 0, 3, 18'h33);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 2, 0);
    cyc(1, 0, 1, 3, 0);
    chk("pipe0 dv", data_valid, 1);
    chk("pipe0 data", data_out, 18'h11);
    cyc(0, 0, 0, 0, 0);
    chk("pipe1 dv", data_valid, 1);
    chk("pipe1 data", data_out, 18'h22);
    cyc(0, 0, 0, 0, 0);
    chk("pipe2 dv", data_valid, 1);
    chk("pipe2 data", data_out, 18'h33);
    cyc(0, 0, 0, 0, 0);
    chk("pipe end dv", data_valid, 0);
    cyc(1, 1, 1, 4, 18'h00077);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("both no dv", data_valid, 0);
    ld_chk(4, 18'h00077, "st_wins4");
    cyc(0, 1, 0, 4, 18'h00055);
    ld_chk(4, 18'h00077, "en_low4");
    cyc(1, 1, 0, 999, 18'h12345);
    cyc(1, 1, 0, 1000, 18'h3ABCD);
    chk("st_range err", addr_error, 1);
    cyc(0, 0, 0, 0, 0);
    chk("st_range err drop", addr_error, 0);
    ld_chk(1000, 18'h0, "ld_range");
    ld_chk(999, 18'h12345, "last_word");
    cyc(1, 0, 1, 1023, 0);
    chk("ld_range err", addr_error, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ld1023 data", data_out, 18'h0);
    cyc(1, 0, 1, 999, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    chk("flush dv", data_valid, 0);
    chk("flush dout", data_out, 0);
    @(negedge clk);
    rst = 0;
    wait_ready();
    ld_chk(999, 18'h0, "after_flush");
    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised single-port data memory for the 18-bit processor's load/store path. Generalises the original data RAM with configurable width, depth and read latency, plus a post-reset clear sequence, a ready signal, a read-valid strobe and out-of-range address detection. It sits between the datapath's load/store control and the register-file writeback mux.

## Interface
- DATA_WIDTH, 18: word width in bits.
- ADDR_WIDTH, 10: address bus width.
- DEPTH, 1024: number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1: cycles from load acceptance to data_valid; legal 1..4.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents untouched.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- memory_enable  in  1  request qualifier.
- is_st  in  1  store request.
- is_ld  in  1  load request.
- address  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  store data.
- ready  out  1  high when a request can be accepted.
- data_out  out  DATA_WIDTH  load result; holds last value.
- data_valid  out  1  one-cycle strobe: data_out updated this cycle.
- addr_error  out  1  one-cycle strobe: out-of-range request accepted.

## Operation
- FSM states: CLEAR, IDLE. rst high → CLEAR if CLEAR_ON_RESET=1, else IDLE.
- CLEAR: clear counter starts at 0; each cycle writes 0 to mem[counter] and increments it; after writing DEPTH-1 → IDLE. ready=0 throughout; all requests ignored (no write, no strobe).
- IDLE: ready=1. A request is accepted when memory_enable && ready && (is_st || is_ld).
- Simultaneous is_st and is_ld: store wins, load dropped (no data_valid).
- Store: mem[address] ← data_in on the acceptance edge.
- Load: mem[address] is read on the acceptance edge and travels down a READ_LATENCY-deep valid/data pipeline; one load accepted per cycle, fully pipelined.
- Out of range (address ≥ DEPTH): store discarded; load still produces data_valid with data_out = 0. In both cases addr_error pulses.
- Store then load to same address in the next cycle: the load returns the new data.
- memory_enable low: is_st/is_ld ignored.

## Timing
- Reset values: data_out=0, data_valid=0, addr_error=0, ready=0, clear counter=0, pipeline valid bits cleared.
- CLEAR_ON_RESET=1: first cycle with rst low is clear cycle 0; ready rises exactly DEPTH cycles after rst's falling edge (1024 by default).
- CLEAR_ON_RESET=0: ready=1 on the first cycle after rst is released.
- Load accepted at edge N → data_out/data_valid valid during the cycle after edge N+READ_LATENCY-1 (READ_LATENCY=1: visible immediately after the acceptance edge, as in the original RAM).
- addr_error: registered, high for the single cycle following the accepting edge.
- rst mid-operation (CLEAR or IDLE, loads in flight): in-flight loads flushed without data_valid; CLEAR restarts from address 0.
- data_valid never asserted while rst is high or during CLEAR.

## Test plan
- Reset/clear: DEPTH=16, CLEAR_ON_RESET=1; preload mem[5]=0x3FFFF, pulse rst, release → ready low for 16 cycles then high; load addr 5 → data_out=0, data_valid one cycle.
- Store/load: store 0x2A5A5 @ 0x00F, load 0x00F next cycle → data_valid after 1 cycle, data_out=0x2A5A5; data_out holds afterwards with data_valid=0.
- Latency/pipelining: READ_LATENCY=3; loads to addrs 1,2,3 on consecutive cycles (preloaded 0x11,0x22,0x33) → data_valid high three consecutive cycles starting 3 cycles later, data 0x11,0x22,0x33 in order.
- Priority/ignore: is_st=is_ld=1, addr 4, data 0x00077 → mem[4]=0x00077, no data_valid; memory_enable=0 with is_st=1 → no write.
- Range: DEPTH=1000, store to 1000 then load 1000 → addr_error pulses after each, load returns 0 with data_valid; mem[999] unchanged.
- Reset mid-load: READ_LATENCY=4, issue load, assert rst 2 cycles later → no data_valid; clear sequence restarts, ready low for DEPTH cycles.
